// File: rtl/sram189_if.sv
// Requester-side bus for the SN74x189 sequencer: two independent
// valid/ready request channels, each with a one-cycle response pulse.
interface sram189_if;
  // Port 0
  logic       req0_valid;
  logic       req0_ready;
  logic       req0_we;
  logic [3:0] req0_addr;
  logic [3:0] req0_wdata;
  logic       rsp0_valid;
  logic [3:0] rsp0_rdata;
  // Port 1
  logic       req1_valid;
  logic       req1_ready;
  logic       req1_we;
  logic [3:0] req1_addr;
  logic [3:0] req1_wdata;
  logic       rsp1_valid;
  logic [3:0] rsp1_rdata;

  // Requester view
  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    input  req0_ready, rsp0_valid, rsp0_rdata,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    input  req1_ready, rsp1_valid, rsp1_rdata
  );

  // Controller view
  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    output req0_ready, rsp0_valid, rsp0_rdata,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    output req1_ready, rsp1_valid, rsp1_rdata
  );
endinterface

// File: rtl/sram189_ctrl.sv
// Sequencer and two-port arbiter for one SN74x189 16x4 asynchronous RAM.
// Every RAM pin and every response signal is a flop output, so the
// asynchronous part never sees decode glitches. Writes bracket the we_
// strobe with one setup cycle and one hold cycle of stable a/d; reads
// wait RD_WAIT cycles with a stable address and un-invert o_.
module sram189_ctrl #(
  parameter int unsigned WE_CYCLES = 1,
  parameter int unsigned RD_WAIT   = 1,
  parameter bit          FIXED_PRI = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  sram189_if.slave   bus,
  output logic [3:0] ram_a,
  output logic [3:0] ram_d,
  output logic       ram_cs_,
  output logic       ram_we_,
  input  logic [3:0] ram_o_,
  output logic       busy
);

  localparam int unsigned CNT_MAX = (WE_CYCLES > RD_WAIT) ? WE_CYCLES : RD_WAIT;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    RSAMPLE
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          op_we_q;
  logic          owner_q;
  logic          last_q;     // 1: port 1 was served most recently
  logic          cs_q;
  logic          we_q;
  logic [3:0]    a_q;
  logic [3:0]    d_q;
  logic          rv0_q;
  logic          rv1_q;
  logic [3:0]    rd0_q;
  logic [3:0]    rd1_q;

  logic          idle;
  logic          gnt1;
  logic          ready0;
  logic          ready1;
  logic          accept;
  logic          op_we_d;
  logic [3:0]    a_d;
  logic [3:0]    d_d;

  assign idle = (state_q == IDLE);

  // Arbitration: a lone requester always wins; on contention either
  // port 0 wins outright or the port not served last wins.
  always_comb begin
    gnt1 = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      gnt1 = FIXED_PRI ? 1'b0 : ~last_q;
    end else begin
      gnt1 = bus.req1_valid;
    end
  end

  assign ready0 = idle & ~rst & bus.req0_valid & ~gnt1;
  assign ready1 = idle & ~rst & bus.req1_valid &  gnt1;
  assign accept = ready0 | ready1;

  // Payload of the granted port, latched on acceptance
  always_comb begin
    op_we_d = bus.req0_we;
    a_d     = bus.req0_addr;
    d_d     = bus.req0_wdata;
    if (gnt1) begin
      op_we_d = bus.req1_we;
      a_d     = bus.req1_addr;
      d_d     = bus.req1_wdata;
    end
  end

  // Operation sequencer; RAM strobes and responses are registered here
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_we_q <= 1'b0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      cs_q    <= 1'b1;
      we_q    <= 1'b1;
      a_q     <= '0;
      d_q     <= '0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      rv0_q <= 1'b0;
      rv1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_we_q <= op_we_d;
            owner_q <= gnt1;
            last_q  <= gnt1;
            a_q     <= a_d;
            d_q     <= d_d;
            cs_q    <= 1'b0;
            we_q    <= 1'b1;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          if (op_we_q) begin
            we_q    <= 1'b0;
            cnt_q   <= CW'(WE_CYCLES - 1);
            state_q <= STROBE;
          end else begin
            cnt_q   <= CW'(RD_WAIT - 1);
            state_q <= RSAMPLE;
          end
        end
        STROBE: begin
          if (cnt_q == '0) begin
            we_q    <= 1'b1;
            state_q <= HOLD;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        HOLD: begin
          cs_q    <= 1'b1;
          state_q <= IDLE;
          if (owner_q) begin
            rv1_q <= 1'b1;
            rd1_q <= '0;
          end else begin
            rv0_q <= 1'b1;
            rd0_q <= '0;
          end
        end
        RSAMPLE: begin
          if (cnt_q == '0) begin
            cs_q    <= 1'b1;
            state_q <= IDLE;
            if (owner_q) begin
              rv1_q <= 1'b1;
              rd1_q <= ~ram_o_;
            end else begin
              rv0_q <= 1'b1;
              rd0_q <= ~ram_o_;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          cs_q    <= 1'b1;
          we_q    <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.rsp0_valid = rv0_q;
  assign bus.rsp0_rdata = rd0_q;
  assign bus.rsp1_valid = rv1_q;
  assign bus.rsp1_rdata = rd1_q;

  assign ram_a   = a_q;
  assign ram_d   = d_q;
  assign ram_cs_ = cs_q;
  assign ram_we_ = we_q;
  assign busy    = ~idle;

endmodule
